// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle main controller: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath selects and enables, and counts retired instructions.
`timescale 1ns/1ps

module multicycle_main_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] retired_o
);

  // state   | meaning
  // IDLE    | halted, waiting for run_i
  // FETCH   | instruction read, PC+4
  // DECODE  | latch opcode, precompute branch target
  // EXEC    | ALU operation / branch resolve
  // MEM     | data memory access
  // WB      | register file write

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t            state;
  state_t            resume;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              legal;
  logic              wait_ready;
  logic              timeout;

  assign legal      = op_i inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI};
  assign wait_ready = (state == S_MEM) ? dmem_ready_i : imem_ready_i;
  // A ready arriving on the limit cycle completes normally.
  assign timeout    = (TIMEOUT_CYC != 0) && ((state == S_FETCH) || (state == S_MEM)) &&
                      !wait_ready && (wait_cnt == WAIT_LAST);
  assign state_o    = state;

  always_comb begin
    resume = S_IDLE;
    if (run_i) resume = S_FETCH;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      retired_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_i) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ready_i) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state    <= resume;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= op_i;
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state    <= resume;
            wait_cnt <= '0;
          end
        end
        S_EXEC: begin
          if (op_q == OP_BEQ) begin
            retired_o <= retired_o + CNT_W'(1);
            state     <= resume;
            wait_cnt  <= '0;
          end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready_i) begin
            if (op_q == OP_SW) begin
              retired_o <= retired_o + CNT_W'(1);
              state     <= resume;
              wait_cnt  <= '0;
            end else begin
              state <= S_WB;
            end
          end else if (timeout) begin
            state    <= resume;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired_o <= retired_o + CNT_W'(1);
          state     <= resume;
          wait_cnt  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req_o   = 1'b0;
    dmem_read_o  = 1'b0;
    dmem_write_o = 1'b0;
    alu_op_o     = 3'b000;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    bus_err_o    = timeout;
    case (state)
      S_FETCH: begin
        imem_req_o  = !timeout;
        alu_src_b_o = 2'b01;
        ir_write_o  = imem_ready_i;
        pc_write_o  = imem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        illegal_o   = !legal;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        case (op_q)
          OP_R:    begin alu_op_o = 3'b010; alu_src_b_o = 2'b00; end
          OP_ADDI: begin alu_op_o = 3'b011; alu_src_b_o = 2'b10; end
          OP_SLTI: begin alu_op_o = 3'b100; alu_src_b_o = 2'b10; end
          OP_LW:   begin alu_op_o = 3'b000; alu_src_b_o = 2'b10; end
          OP_SW:   begin alu_op_o = 3'b101; alu_src_b_o = 2'b10; end
          OP_BEQ: begin
            alu_op_o    = 3'b001;
            alu_src_b_o = 2'b00;
            pc_src_o    = 1'b1;
            pc_write_o  = zero_i;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_read_o  = (op_q == OP_LW) && !timeout;
        dmem_write_o = (op_q == OP_SW) && !timeout;
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_q == OP_R);
        mem_to_reg_o = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl: per-cycle expectations queued with the stimulus,
// popped and compared each cycle.
`timescale 1ns/1ps

module tb_multicycle_main_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  logic       clk, rst_i, run_i, zero_i, imem_ready_i, dmem_ready_i;
  logic [5:0] op_i;
  logic       imem_req_o, dmem_read_o, dmem_write_o, alu_src_a_o;
  logic [2:0] alu_op_o, state_o;
  logic [1:0] alu_src_b_o;
  logic       ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o, mem_to_reg_o;
  logic       illegal_o, bus_err_o;
  logic [2:0] retired_o;
  logic [16:0] act;

  typedef struct packed {
    logic       run;
    logic       zero;
    logic       irdy;
    logic       drdy;
    logic [5:0] op;
    logic [2:0] st;
    logic       to;
    logic [2:0] ret;
  } cyc_t;

  cyc_t       sb[$];
  logic [2:0] model_ret;
  int         n_err, n_checks;

  multicycle_main_ctrl #(.CNT_W(3), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .op_i(op_i), .zero_i(zero_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
    .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .state_o(state_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o), .retired_o(retired_o)
  );

  assign act = {imem_req_o, dmem_read_o, dmem_write_o, alu_op_o, alu_src_a_o, alu_src_b_o,
                ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                illegal_o, bus_err_o};

  always #5 clk = ~clk;

  // Expected control bundle for one cycle, straight from the state/opcode tables.
  function automatic logic [16:0] exp_bundle(cyc_t c);
    logic ireq = 1'b0, drd = 1'b0, dwr = 1'b0, srca = 1'b0, irw = 1'b0, pcw = 1'b0;
    logic pcs = 1'b0, rw = 1'b0, rdst = 1'b0, m2r = 1'b0, ill = 1'b0, berr = 1'b0;
    logic [2:0] alu = 3'b000;
    logic [1:0] srcb = 2'b00;
    case (c.st)
      3'd1: begin
        ireq = !c.to; srcb = 2'b01; irw = c.irdy && !c.to; pcw = c.irdy && !c.to; berr = c.to;
      end
      3'd2: begin
        srcb = 2'b11;
        ill  = !(c.op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI});
      end
      3'd3: begin
        srca = 1'b1;
        if (c.op == OP_R)    begin alu = 3'b010; srcb = 2'b00; end
        if (c.op == OP_ADDI) begin alu = 3'b011; srcb = 2'b10; end
        if (c.op == OP_SLTI) begin alu = 3'b100; srcb = 2'b10; end
        if (c.op == OP_LW)   begin alu = 3'b000; srcb = 2'b10; end
        if (c.op == OP_SW)   begin alu = 3'b101; srcb = 2'b10; end
        if (c.op == OP_BEQ)  begin alu = 3'b001; srcb = 2'b00; pcs = 1'b1; pcw = c.zero; end
      end
      3'd4: begin
        drd = (c.op == OP_LW) && !c.to; dwr = (c.op == OP_SW) && !c.to; berr = c.to;
      end
      3'd5: begin
        rw = 1'b1; rdst = (c.op == OP_R); m2r = (c.op == OP_LW);
      end
      default: ;
    endcase
    return {ireq, drd, dwr, alu, srca, srcb, irw, pcw, pcs, rw, rdst, m2r, ill, berr};
  endfunction

  task automatic push(input logic [2:0] st, input logic [5:0] op, input logic irdy,
                      input logic drdy, input logic zero, input logic run, input logic to,
                      input logic retire);
    cyc_t c;
    c.st = st; c.op = op; c.irdy = irdy; c.drdy = drdy; c.zero = zero;
    c.run = run; c.to = to; c.ret = model_ret;
    sb.push_back(c);
    if (retire) model_ret = model_ret + 3'd1;
  endtask

  // Expected cycle sequence of one instruction with the given ready stalls.
  task automatic push_instr(input logic [5:0] op, input int istall, input int dstall,
                            input logic zero, input logic run);
    for (int i = 0; i < istall; i++) push(3'd1, op, 1'b0, 1'b1, zero, run, 1'b0, 1'b0);
    push(3'd1, op, 1'b1, 1'b1, zero, run, 1'b0, 1'b0);
    push(3'd2, op, 1'b1, 1'b1, zero, run, 1'b0, 1'b0);
    if (!(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI})) return;
    push(3'd3, op, 1'b1, 1'b1, zero, run, 1'b0, op == OP_BEQ);
    if (op == OP_BEQ) return;
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i < dstall; i++) push(3'd4, op, 1'b1, 1'b0, zero, run, 1'b0, 1'b0);
      push(3'd4, op, 1'b1, 1'b1, zero, run, 1'b0, op == OP_SW);
      if (op == OP_SW) return;
    end
    push(3'd5, op, 1'b1, 1'b1, zero, run, 1'b0, 1'b1);
  endtask

  task automatic apply(output cyc_t c);
    c = sb.pop_front();
    run_i = c.run; op_i = c.op; zero_i = c.zero;
    imem_ready_i = c.irdy; dmem_ready_i = c.drdy;
    @(negedge clk);
  endtask

  task automatic test_reset;
    cyc_t c;
    #3;
    n_checks += 3;
    if (act !== 17'd0) begin n_err++; $display("FAIL reset outputs: got %h expected 0", act); end
    if (state_o !== 3'd0) begin n_err++; $display("FAIL reset state: got %0d expected 0", state_o); end
    if (retired_o !== 3'd0) begin n_err++; $display("FAIL reset retired: got %0d expected 0", retired_o); end
    run_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL reset hold: got %0d expected 0", state_o); end
    rst_i = 1'b0;
    push(3'd0, OP_R, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL reset_idle state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL reset_idle outputs st=%0d: got %h expected %h", c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL reset_idle retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add;
    cyc_t c;
    push_instr(OP_R, 0, 0, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL add state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL add outputs st=%0d: got %h expected %h", c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL add retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall;
    cyc_t c;
    push_instr(OP_LW, 0, 3, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL lw state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL lw outputs st=%0d: got %h expected %h", c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL lw retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq;
    cyc_t c;
    push_instr(OP_BEQ, 0, 0, 1'b1, 1'b1);
    push_instr(OP_BEQ, 0, 0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL beq state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL beq outputs st=%0d zero=%0d: got %h expected %h", c.st, c.zero, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL beq retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    cyc_t c;
    push_instr(OP_ADDI, 0, 0, 1'b1, 1'b1);
    push_instr(OP_SLTI, 0, 0, 1'b1, 1'b1);
    push_instr(OP_SW, 0, 0, 1'b1, 1'b1);
    push_instr(OP_R, 0, 0, 1'b0, 1'b1);
    push_instr(OP_ADDI, 2, 0, 1'b1, 1'b1);
    push_instr(OP_SW, 1, 2, 1'b1, 1'b1);
    push_instr(OP_R, 3, 0, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL b2b state op=%b: got %0d expected %0d", c.op, state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL b2b outputs op=%b st=%0d: got %h expected %h", c.op, c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL b2b retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    cyc_t c;
    push_instr(6'b111111, 0, 0, 1'b1, 1'b1);
    push_instr(6'b000010, 0, 0, 1'b1, 1'b1);
    push_instr(OP_R, 0, 0, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL illegal state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL illegal outputs op=%b st=%0d: got %h expected %h", c.op, c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL illegal retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    cyc_t c;
    for (int i = 0; i < 3; i++) push(3'd1, OP_R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd1, OP_R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push_instr(OP_R, 3, 0, 1'b1, 1'b1);
    push(3'd1, OP_LW, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd2, OP_LW, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd3, OP_LW, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(3'd4, OP_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd4, OP_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_instr(OP_SW, 0, 3, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL timeout state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL timeout outputs st=%0d to=%0d: got %h expected %h", c.st, c.to, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL timeout retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run_low;
    cyc_t c;
    push_instr(OP_R, 0, 0, 1'b1, 1'b0);
    push(3'd0, OP_R, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, OP_R, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, OP_R, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
    push(3'd0, OP_R, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL run_low state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL run_low outputs st=%0d: got %h expected %h", c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL run_low retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap;
    cyc_t c;
    for (int i = 0; i < 9; i++) push_instr(OP_BEQ, 0, 0, logic'(i % 2), 1'b1);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL wrap state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL wrap outputs st=%0d: got %h expected %h", c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL wrap retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    cyc_t c;
    push(3'd1, OP_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd2, OP_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd3, OP_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd4, OP_LW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      apply(c);
      n_checks += 3;
      if (state_o !== c.st) begin n_err++; $display("FAIL reset_mid state: got %0d expected %0d", state_o, c.st); end
      if (act !== exp_bundle(c)) begin n_err++; $display("FAIL reset_mid outputs st=%0d: got %h expected %h", c.st, act, exp_bundle(c)); end
      if (retired_o !== c.ret) begin n_err++; $display("FAIL reset_mid retired: got %0d expected %0d", retired_o, c.ret); end
      @(posedge clk); #1;
    end
    #2;
    n_checks++;
    if (dmem_read_o !== 1'b1) begin n_err++; $display("FAIL reset_mid read before reset: got %0d expected 1", dmem_read_o); end
    rst_i = 1'b1;
    #1;
    model_ret = 3'd0;
    n_checks += 3;
    if (act !== 17'd0) begin n_err++; $display("FAIL reset_mid outputs: got %h expected 0", act); end
    if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_mid async state: got %0d expected 0", state_o); end
    if (retired_o !== model_ret) begin n_err++; $display("FAIL reset_mid retired: got %0d expected %0d", retired_o, model_ret); end
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    n_checks += 2;
    if (state_o !== 3'd1) begin n_err++; $display("FAIL reset_mid restart state: got %0d expected 1", state_o); end
    if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL reset_mid restart req: got %0d expected 1", imem_req_o); end
  endtask

  initial begin
    clk = 1'b0; rst_i = 1'b1; run_i = 1'b0; op_i = 6'd0; zero_i = 1'b0;
    imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    model_ret = 3'd0; n_err = 0; n_checks = 0;
    test_reset;
    test_add;
    test_lw_stall;
    test_beq;
    test_back_to_back;
    test_illegal;
    test_timeout;
    test_run_low;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
